// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
// Holds the FSM state encoding and the one-hot result vector layout.
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Result vector layout: {greater, equal, less}
   localparam logic [2:0] RES_NONE = 3'b000;
   localparam logic [2:0] RES_GT   = 3'b100;
   localparam logic [2:0] RES_EQ   = 3'b010;
   localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/serial_comparator_slice_cmp.sv
// Combinational unsigned compare of one DIGIT-wide slice.
// Exactly one of gt/eq/lt is high for any input pair.
module slice_cmp #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   output logic             gt_o,
   output logic             eq_o,
   output logic             lt_o
);

   assign gt_o = (a_i >  b_i);
   assign eq_o = (a_i == b_i);
   assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/serial_comparator.sv
// Digit-serial comparator: walks slices MSB-first, one per cycle,
// stopping early at the first differing slice.
module serial_comparator
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             greater,
   output logic             equal,
   output logic             less
);

   localparam int N    = WIDTH / DIGIT;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [2:0]        res_q, res_d;

   logic [WIDTH-1:0]  msb_m;
   logic [DIGIT-1:0]  sa, sb;
   logic              s_gt, s_eq, s_lt;

   // Signed compare becomes unsigned once both sign bits are flipped
   always_comb begin
      msb_m          = '0;
      msb_m[WIDTH-1] = signed_mode;
   end

   // Route the slice addressed by idx_q to the single slice comparator
   always_comb begin
      sa = '0;
      sb = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IDXW'(i)) begin
            sa = a_q[i*DIGIT +: DIGIT];
            sb = b_q[i*DIGIT +: DIGIT];
         end
      end
   end

   slice_cmp #(
      .DIGIT (DIGIT)
   ) u_slice (
      .a_i  (sa),
      .b_i  (sb),
      .gt_o (s_gt),
      .eq_o (s_eq),
      .lt_o (s_lt)
   );

   // Next-state: capture on start, scan slices, write result on exit
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               a_d     = a ^ msb_m;
               b_d     = b ^ msb_m;
               idx_d   = IDXW'(N - 1);
               state_d = CMP;
            end
         end
         CMP: begin
            if (!s_eq) begin
               res_d   = s_gt ? RES_GT : RES_LT;
               state_d = DONE;
            end else if (idx_q == '0) begin
               res_d   = RES_EQ;
               state_d = DONE;
            end else begin
               idx_d   = idx_q - IDXW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= RES_NONE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

   assign busy    = (state_q == CMP);
   assign done    = (state_q == DONE);
   assign greater = res_q[2];
   assign equal   = res_q[1];
   assign less    = res_q[0];

   logic unused_ok;
   assign unused_ok = s_lt;

endmodule
